// File: rtl/dpram_pkg.sv
// Shared constants and owner type for the dual-port RAM arbiter.
// Also holds the saturating burst-counter helper used by the arbiter core.
`timescale 1ns/1ps
package dpram_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 5;
  localparam int RAM_DEPTH = 32;
  localparam int BURST_W   = 4;   // holds BURST_MAX up to 15

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  function automatic logic [BURST_W-1:0] sat_inc(
    input logic [BURST_W-1:0] value,
    input logic [BURST_W-1:0] limit
  );
    return (value < limit) ? value + 1'b1 : value;
  endfunction

endpackage

// File: rtl/rr2_burst_arb.sv
// Two-way round-robin arbiter that lets the current owner keep up to
// BURST_MAX consecutive grants while the other client is also requesting.
`timescale 1ns/1ps
module rr2_burst_arb
  import dpram_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

  owner_e             owner_reg, owner_next;
  logic [BURST_W-1:0] cnt_reg, cnt_next;
  logic               started_reg;
  logic               hold_ok;
  logic [1:0]         gnt_raw;

  // Until the first grant after reset there is no burst to continue, so a
  // tie goes to the client that is not last_owner (A, since reset owner is B).
  always_comb begin
    gnt_raw = 2'b00;
    hold_ok = started_reg && (cnt_reg < BURST_LIM);
    case (req)
      2'b01:   gnt_raw = 2'b01;
      2'b10:   gnt_raw = 2'b10;
      2'b11:   gnt_raw = ((owner_reg == OWN_A) == hold_ok) ? 2'b01 : 2'b10;
      default: gnt_raw = 2'b00;
    endcase
  end

  assign gnt = rst_n ? gnt_raw : 2'b00;

  always_comb begin
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    if (gnt_raw == 2'b00) begin
      cnt_next = '0;
    end else if ((gnt_raw[0] && owner_reg == OWN_A) ||
                 (gnt_raw[1] && owner_reg == OWN_B)) begin
      cnt_next = sat_inc(cnt_reg, BURST_LIM);
    end else begin
      owner_next = gnt_raw[0] ? OWN_A : OWN_B;
      cnt_next   = BURST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg   <= OWN_B;
      cnt_reg     <= '0;
      started_reg <= 1'b0;
    end else begin
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      if (gnt_raw != 2'b00) begin
        started_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one 32x8 dual-port RAM between clients A and B: one access per cycle,
// drives the RAM bus from the winner and registers read data back to it.
`timescale 1ns/1ps
module dpram_arbiter
  import dpram_pkg::*;
#(
  parameter int DATA_W    = dpram_pkg::DATA_W,
  parameter int ADDR_W    = dpram_pkg::ADDR_W,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_en_a,
  output logic              mem_en_b,
  input  logic [DATA_W-1:0] mem_rdata_a,
  input  logic [DATA_W-1:0] mem_rdata_b
);

  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [1:0]        gnt_vec;
  logic [DATA_W-1:0] mem_rdata_vec [2];

  assign req_vec          = {req_b, req_a};
  assign we_vec           = {we_b, we_a};
  assign mem_rdata_vec[0] = mem_rdata_a;
  assign mem_rdata_vec[1] = mem_rdata_b;

  rr2_burst_arb #(
    .BURST_MAX (BURST_MAX)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vec),
    .gnt   (gnt_vec)
  );

  assign gnt_a    = gnt_vec[0];
  assign gnt_b    = gnt_vec[1];
  assign mem_en_a = gnt_vec[0];
  assign mem_en_b = gnt_vec[1];

  // Idle bus is driven to zero so the RAM never sees stale address/data.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    if (gnt_vec[0]) begin
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
      mem_wr_en = we_a;
    end else if (gnt_vec[1]) begin
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
      mem_wr_en = we_b;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic              rvalid_reg;
      logic [DATA_W-1:0] rdata_reg;
      logic              rd_hit;

      assign rd_hit = gnt_vec[gi] && !we_vec[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= rd_hit;
          if (rd_hit) begin
            rdata_reg <= mem_rdata_vec[gi];
          end
        end
      end
    end
  endgenerate

  assign rvalid_a = g_rd[0].rvalid_reg;
  assign rdata_a  = g_rd[0].rdata_reg;
  assign rvalid_b = g_rd[1].rvalid_reg;
  assign rdata_b  = g_rd[1].rdata_reg;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural 32x8 RAM on the mem_* bus.
`timescale 1ns/1ps
module tb_dpram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [4:0] addr_a = '0, addr_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0;
  logic       gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata_a, mem_rdata_b;
  logic       mem_wr_en, mem_en_a, mem_en_b;

  logic [7:0] ram [32];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.DATA_W(8), .ADDR_W(5), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_en_a(mem_en_a), .mem_en_b(mem_en_b),
    .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b)
  );

  // RAM: shared address/data bus, write on the edge, combinational reads.
  always @(posedge clk)
    if (mem_wr_en && (mem_en_a || mem_en_b)) ram[mem_addr] <= mem_wdata;
  assign mem_rdata_a = mem_en_a ? ram[mem_addr] : 8'h00;
  assign mem_rdata_b = mem_en_b ? ram[mem_addr] : 8'h00;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    req_a = 1; we_a = 1; addr_a = 5'd9; wdata_a = 8'hEE;
    cycle();
    checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL rst_gnt_a got=%b exp=0", gnt_a); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", mem_wr_en); end
    checks++; if (mem_en_a !== 1'b0) begin errors++; $display("FAIL rst_en_a got=%b exp=0", mem_en_a); end
    checks++; if ({rvalid_a, rvalid_b} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got=%b exp=00", {rvalid_a, rvalid_b}); end
    checks++; if ({rdata_a, rdata_b} !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h exp=0000", {rdata_a, rdata_b}); end
    idle_inputs();
    cycle();
    rst_n = 1;
    $display("reset: done");
  endtask

  task automatic test_write_read();
    req_a = 1; we_a = 1; addr_a = 5'd3; wdata_a = 8'hA5;
    #1;
    checks++; if ({gnt_a, gnt_b} !== 2'b10) begin errors++; $display("FAIL wr_gnt got=%b exp=10", {gnt_a, gnt_b}); end
    checks++; if ({mem_wr_en, mem_en_a, mem_en_b, mem_addr, mem_wdata} !== {3'b110, 5'd3, 8'hA5})
      begin errors++; $display("FAIL wr_bus got=%b%b%b/%0d/%h exp=110/3/a5", mem_wr_en, mem_en_a, mem_en_b, mem_addr, mem_wdata); end
    $display("A write addr=3 data=a5");
    cycle();
    we_a = 0;
    #1;
    checks++; if ({gnt_a, mem_wr_en} !== 2'b10) begin errors++; $display("FAIL rd_gnt got=%b exp=10", {gnt_a, mem_wr_en}); end
    cycle();
    idle_inputs();
    checks++; if ({rvalid_a, rdata_a} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL rd_data got=%b/%h exp=1/a5", rvalid_a, rdata_a); end
    $display("A read addr=3 data=%h", rdata_a);
    cycle();
    checks++; if ({rvalid_a, rdata_a} !== {1'b0, 8'hA5}) begin errors++; $display("FAIL rd_hold got=%b/%h exp=0/a5", rvalid_a, rdata_a); end
  endtask

  task automatic test_tie_burst();
    bit [11:0] seq_a;
    seq_a = 12'b1111_0000_1111;
    apply_reset();
    req_a = 1; req_b = 1; we_a = 0; we_b = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if ({gnt_a, gnt_b} !== {seq_a[i], ~seq_a[i]}) begin
        errors++; $display("FAIL tie_seq[%0d] got=%b exp=%b", i, {gnt_a, gnt_b}, {seq_a[i], ~seq_a[i]});
      end
      $display("tie cycle %0d gnt_a=%b gnt_b=%b", i, gnt_a, gnt_b);
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      req_b = 1; we_b = 1; addr_b = 5'(i); wdata_b = 8'(16 + i);
      cycle();
    end
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        checks++;
        if ({rvalid_b, rdata_b} !== {1'b1, 8'(15 + i)}) begin
          errors++; $display("FAIL b2b_rdata[%0d] got=%b/%h exp=1/%h", i - 1, rvalid_b, rdata_b, 8'(15 + i));
        end
        $display("B read addr=%0d data=%h", i - 1, rdata_b);
      end
      if (i < 10) begin
        req_b = 1; we_b = 0; addr_b = 5'(i);
        #1;
        checks++; if (gnt_b !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", i, gnt_b); end
      end else begin
        idle_inputs();
      end
      cycle();
    end
    checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", rvalid_b); end
  endtask

  task automatic test_idle_resets_burst();
    bit [4:0] seq_a;
    seq_a = 5'b01111;
    req_a = 1; we_a = 0;
    cycle();
    cycle();
    idle_inputs();
    cycle();
    req_a = 1; req_b = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({gnt_a, gnt_b} !== {seq_a[i], ~seq_a[i]}) begin
        errors++; $display("FAIL idle_seq[%0d] got=%b exp=%b", i, {gnt_a, gnt_b}, {seq_a[i], ~seq_a[i]});
      end
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_reset_mid_read();
    req_b = 1; we_b = 0; addr_b = 5'd7;
    #1;
    checks++; if (gnt_b !== 1'b1) begin errors++; $display("FAIL mid_gnt got=%b exp=1", gnt_b); end
    #2;
    rst_n = 0;
    req_a = 1; we_a = 1; addr_a = 5'd7; wdata_a = 8'h99;
    #1;
    checks++; if ({gnt_a, gnt_b, mem_en_a, mem_en_b} !== 4'b0000) begin errors++; $display("FAIL mid_force got=%b exp=0000", {gnt_a, gnt_b, mem_en_a, mem_en_b}); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if ({mem_wr_en, rvalid_b} !== 2'b00) begin errors++; $display("FAIL mid_rst[%0d] got=%b exp=00", i, {mem_wr_en, rvalid_b}); end
    end
    idle_inputs();
    rst_n = 1;
    req_a = 1; req_b = 1; addr_a = 5'd0; addr_b = 5'd7;
    #1;
    checks++; if ({gnt_a, gnt_b} !== 2'b10) begin errors++; $display("FAIL post_rst_tie got=%b exp=10", {gnt_a, gnt_b}); end
    cycle();
    idle_inputs();
    checks++; if ({rvalid_a, rdata_a, rvalid_b} !== {1'b1, 8'h10, 1'b0}) begin errors++; $display("FAIL post_rst_rd got=%b/%h/%b exp=1/10/0", rvalid_a, rdata_a, rvalid_b); end
    $display("A read addr=0 data=%h after reset", rdata_a);
    cycle();
  endtask

  task automatic test_write_then_read_other();
    req_a = 1; we_a = 1; addr_a = 5'd31; wdata_a = 8'h3C;
    req_b = 1; we_b = 0; addr_b = 5'd31;
    #1;
    checks++; if ({gnt_a, gnt_b, mem_en_a, mem_en_b} !== 4'b1010) begin errors++; $display("FAIL xw_gnt got=%b exp=1010", {gnt_a, gnt_b, mem_en_a, mem_en_b}); end
    cycle();
    req_a = 0; we_a = 0;
    #1;
    checks++; if ({gnt_a, gnt_b, mem_en_a, mem_en_b} !== 4'b0101) begin errors++; $display("FAIL xr_gnt got=%b exp=0101", {gnt_a, gnt_b, mem_en_a, mem_en_b}); end
    cycle();
    idle_inputs();
    checks++; if ({rvalid_b, rdata_b} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL xr_data got=%b/%h exp=1/3c", rvalid_b, rdata_b); end
    checks++; if (rdata_a !== 8'h10) begin errors++; $display("FAIL xr_hold_a got=%h exp=10", rdata_a); end
    $display("B read addr=31 data=%h", rdata_b);
    cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie_burst();
    test_back_to_back();
    test_idle_resets_burst();
    test_reset_mid_read();
    test_write_then_read_other();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Two-requester arbiter that shares one 32x8 dual-port RAM instance (single shared address/data bus, per-port enables, combinational read) between clients A and B.
- Grants at most one access per cycle, drives the RAM's address, write data, write enable and port enables, and registers the read data back to the winning client.
- Fairness is round-robin with a bounded burst. A client holding `req` may keep ownership for up to `BURST_MAX` consecutive grants while the other client waits.

Parameters:
- `DATA_W`, 8: RAM word width.
- `ADDR_W`, 5: RAM address width (32 words).
- `BURST_MAX`, 4: maximum consecutive grants to one client while the other is requesting. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_a`  in  1  client A requests an access this cycle.
- `we_a`  in  1  client A access is a write (1) or read (0).
- `addr_a`  in  `ADDR_W`  client A address.
- `wdata_a`  in  `DATA_W`  client A write data.
- `gnt_a`  out  1  client A access performed at this cycle's closing edge.
- `rvalid_a`  out  1  `rdata_a` is valid (one-cycle pulse).
- `rdata_a`  out  `DATA_W`  registered read data for A.
- `req_b`, `we_b`, `addr_b`, `wdata_b`, `gnt_b`, `rvalid_b`, `rdata_b`: same as A, for client B.
- `mem_addr`  out  `ADDR_W`  to RAM `addr`.
- `mem_wdata`  out  `DATA_W`  to RAM `data_in`.
- `mem_wr_en`  out  1  to RAM `wr_en`.
- `mem_en_a`  out  1  to RAM `port_A_enb`.
- `mem_en_b`  out  1  to RAM `port_B_enb`.
- `mem_rdata_a`  in  `DATA_W`  from RAM `data_out_A`.
- `mem_rdata_b`  in  `DATA_W`  from RAM `data_out_B`.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset state:
  - `last_owner` = B, so A wins the first tie.
  - `burst_cnt` = 0.
  - `rvalid_a`/`rvalid_b` = 0; `rdata_a`/`rdata_b` = 0.
- While `rst_n` = 0, all grant and `mem_*` enable outputs are forced to 0. No RAM write can occur on an edge during reset.
- Grant decision is combinational from `req_a`, `req_b`, `last_owner` and `burst_cnt` within the same cycle. `gnt_x` is never asserted without `req_x`, and `gnt_a` and `gnt_b` are mutually exclusive.
- Arbitration rules:
  - Neither client requesting: no grant.
  - Only one client requesting: that client is granted.
  - Both requesting, `last_owner` = X and `burst_cnt` < `BURST_MAX`: X is granted.
  - Both requesting otherwise: the other client is granted.
- Counter update at each edge:
  - Grant to `last_owner`: `burst_cnt` increments, saturating at `BURST_MAX`.
  - Grant to the other client: `last_owner` switches and `burst_cnt` = 1.
  - No grant: `burst_cnt` = 0 and `last_owner` holds. An idle cycle ends a burst.
- Memory drive when X is granted:
  - `mem_addr` = `addr_x`, `mem_wdata` = `wdata_x`, `mem_wr_en` = `we_x`, `mem_en_x` = 1; the other enable is 0.
  - Without a grant, all enables are 0 and the `mem_*` buses are 0.
- Write latency: the write commits at the closing edge of the grant cycle. A subsequent read of that address, granted in the next cycle, returns the new data.
- Read latency: for a granted read, `rdata_x` <= `mem_rdata_x` at the closing edge of the grant cycle, and `rvalid_x` = 1 for exactly the following cycle. Back-to-back reads give continuous `rvalid` pulses.
- `rdata_x` holds its value when there is no read, and is not cleared by writes.
- Handshake: the client holds `req`/`we`/`addr`/`wdata` stable until it sees `gnt`. A client that keeps `req` high after `gnt` is requesting a new access.
- Reset mid-operation: a read granted in the cycle `rst_n` falls produces no `rvalid`. Counters and `last_owner` return to reset values immediately.
- Starvation bound: with both clients requesting continuously, neither waits more than `BURST_MAX` cycles.

Decomposition:
- Shared package (`dpram_pkg`): `DATA_W`, `ADDR_W` and `RAM_DEPTH` = 32 constants; an owner enum (`OWN_A`, `OWN_B`) used for `last_owner`.
- One sub-module is natural: `rr2_burst_arb`, containing the owner/`burst_cnt` state and the grant logic, with ports `req[1:0]` in and `gnt[1:0]` out.
- The top level does the mux to `mem_*` and the read-data registers.

Test Plan:
1. Reset, then A writes 0xA5 to address 3 and reads it back in the next cycle -> `gnt_a` in both cycles; `rvalid_a` = 1 with `rdata_a` = 0xA5 one cycle after the read grant.
2. First-cycle tie with `BURST_MAX` = 4, `req_a` and `req_b` held high -> grant sequence A,A,A,A,B,B,B,B,A…; never two grants in one cycle.
3. B alone issues 10 consecutive reads of addresses 0..9, preloaded 0x10..0x19 -> 10 consecutive `gnt_b`; `rvalid_b` continuous for 10 cycles delayed by one; data 0x10..0x19.
4. A bursts 2 grants, idles 1 cycle, then both request -> A granted (`burst_cnt` was reset to 0 by the idle cycle, `last_owner` = A); first B grant only after 4 A grants.
5. `rst_n` asserted low mid-read, during the grant cycle of a B read at address 7 -> no `rvalid_b`; `mem_wr_en` = 0 throughout reset; after release a tie grants A first.
6. A writes 0x3C to address 31 while B reads address 31 in the next cycle -> `rdata_b` = 0x3C; `mem_en_a`/`mem_en_b` never both high.
